cu_edge_data_unpack: RTL and testbench



---
 rtl/cu_edge_data_unpack_pkg.sv | 19 +
 rtl/cu_edge_data_unpack_if.sv | 37 +++
 rtl/cu_edge_data_unpack_fifo.sv | 70 +++++++
 rtl/cu_edge_data_unpack.sv | 125 ++++++++++++
 tb/tb_cu_edge_data_unpack.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_edge_data_unpack_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu_pkg
// Shared cache-line / vertex-ID geometry for the edge data unpacker.
// Revision: 1.0
// ---------------------------------------------------------------------------
package cu_pkg;

  localparam int CACHELINE_SIZE_BITS = 512;
  localparam int VERTEX_ID_BITS      = 32;
  localparam int ELEMS_PER_LINE      = CACHELINE_SIZE_BITS / VERTEX_ID_BITS;

  // Width of an element count that can express 0..elements-per-line inclusive.
  function automatic int count_width(input int line_w, input int elem_w);
    return $clog2(line_w / elem_w) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cu_edge_data_unpack_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu_edge_data_unpack_if
// Line input bus, element output handshake and status flags of the unpacker.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface cu_edge_data_unpack_if
  import cu_pkg::*;
#(
  parameter int LINE_WIDTH = CACHELINE_SIZE_BITS,
  parameter int ELEM_WIDTH = VERTEX_ID_BITS
);

  localparam int CNT_W = count_width(LINE_WIDTH, ELEM_WIDTH);

  logic [LINE_WIDTH-1:0] line_in;
  logic                  line_in_valid;
  logic [CNT_W-1:0]      elem_count_in;
  logic [ELEM_WIDTH-1:0] elem_out;
  logic                  elem_out_valid;
  logic                  elem_out_ready;
  logic                  almost_full;
  logic                  empty;
  logic                  overflow_err;

  modport master (
    output line_in, line_in_valid, elem_count_in, elem_out_ready,
    input  elem_out, elem_out_valid, almost_full, empty, overflow_err
  );

  modport slave (
    input  line_in, line_in_valid, elem_count_in, elem_out_ready,
    output elem_out, elem_out_valid, almost_full, empty, overflow_err
  );

endinterface
`default_nettype wire

// File: rtl/cu_edge_data_unpack_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_lines_sync
// Synchronous line FIFO with combinational head read and occupancy output.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_lines_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clock,
  input  wire logic             rst,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head,
  output logic      [OCC_W-1:0] occupancy,
  output logic                  full,
  output logic                  empty
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_do_push;
  logic             w_do_pop;

  assign occupancy = r_occ;
  assign full      = (r_occ == FULL_OCC);
  assign empty     = (r_occ == '0);
  assign head      = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot the push needs.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cu_edge_data_unpack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cu_edge_data_unpack
// Buffers cache lines of vertex IDs and streams them out one element per cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module cu_edge_data_unpack
  import cu_pkg::*;
#(
  parameter int LINE_WIDTH = CACHELINE_SIZE_BITS,
  parameter int ELEM_WIDTH = VERTEX_ID_BITS,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = 4
) (
  input wire logic              clock,
  input wire logic              rst,
  cu_edge_data_unpack_if.slave  bus
);

  localparam int EPL     = LINE_WIDTH / ELEM_WIDTH;
  localparam int CNT_W   = count_width(LINE_WIDTH, ELEM_WIDTH);
  localparam int IDX_W   = (EPL > 1) ? $clog2(EPL) : 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = CNT_W + LINE_WIDTH;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(EPL);
  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_EMIT = 1'b1;

  logic [CNT_W-1:0]      w_cnt_clamped;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_load;
  logic                  w_last;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic [LINE_WIDTH-1:0] w_head_line;
  logic [CNT_W-1:0]      w_head_cnt;
  logic [OCC_W-1:0]      w_occ;
  logic [ELEM_WIDTH-1:0] w_elems [EPL];

  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [ELEM_WIDTH-1:0] r_elem;
  logic                  r_ovf;

  always_comb begin
    w_cnt_clamped = bus.elem_count_in;
    if (bus.elem_count_in > MAX_CNT) begin
      w_cnt_clamped = MAX_CNT;
    end
  end

  // Zero-count lines carry nothing and never reach the FIFO.
  assign w_push = bus.line_in_valid && (bus.elem_count_in != '0);

  fifo_lines_sync #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (w_push),
    .push_data ({w_cnt_clamped, bus.line_in}),
    .pop       (w_pop),
    .head      (w_head),
    .occupancy (w_occ),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  assign {w_head_cnt, w_head_line} = w_head;

  generate
    for (genvar g = 0; g < EPL; g++) begin : g_unpack
      assign w_elems[g] = w_head_line[g*ELEM_WIDTH +: ELEM_WIDTH];
    end
  endgenerate

  // The output register takes a new element whenever it is empty or draining.
  assign w_load = !w_fifo_empty && ((r_state == ST_IDLE) || bus.elem_out_ready);
  assign w_last = (CNT_W'(r_idx) == (w_head_cnt - CNT_W'(1)));
  assign w_pop  = w_load && w_last;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_elem  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push && w_fifo_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_elem  <= w_elems[r_idx];
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (w_load) begin
            r_elem <= w_elems[r_idx];
            r_idx  <= w_last ? '0 : r_idx + 1'b1;
          end else if (bus.elem_out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.elem_out       = r_elem;
  assign bus.elem_out_valid = (r_state == ST_EMIT);
  assign bus.overflow_err   = r_ovf;
  assign bus.almost_full    = ((FIFO_DEPTH - int'(w_occ)) <= AF_THRESH);
  assign bus.empty          = (w_occ == '0) && (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cu_edge_data_unpack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cu_edge_data_unpack
// Directed and randomized checks of the unpacker against a queue-based model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_cu_edge_data_unpack;
  import cu_pkg::*;

  localparam int LW    = 512;
  localparam int EW    = 32;
  localparam int EPL   = LW / EW;
  localparam int CW    = $clog2(EPL) + 1;
  localparam int DEPTH = 8;
  localparam int AFT   = 4;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  logic [LW-1:0] rl;

  cu_edge_data_unpack_if #(.LINE_WIDTH(LW), .ELEM_WIDTH(EW)) bus ();

  cu_edge_data_unpack #(
    .LINE_WIDTH (LW),
    .ELEM_WIDTH (EW),
    .FIFO_DEPTH (DEPTH),
    .AF_THRESH  (AFT)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: elements not yet loaded into the output slot, per-line remaining counts,
  // and the single element currently offered to the consumer.
  logic [EW-1:0] mq[$];
  int            lq[$];
  logic          m_valid = 1'b0;
  logic [EW-1:0] m_out   = '0;
  logic          m_ovf   = 1'b0;
  logic          started = 1'b0;

  always @(posedge clock) begin
    if (rst) begin
      mq.delete();
      lq.delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else begin
      automatic int occ  = lq.size();
      automatic bit take = (!m_valid || bus.elem_out_ready) && (occ > 0);
      automatic bit freed = take && (lq[0] == 1);
      automatic int n = (int'(bus.elem_count_in) > EPL) ? EPL : int'(bus.elem_count_in);
      if (take) begin
        m_out = mq.pop_front();
        lq[0] = lq[0] - 1;
        if (lq[0] == 0) void'(lq.pop_front());
        m_valid = 1'b1;
      end else if (bus.elem_out_ready) begin
        m_valid = 1'b0;
      end
      if (bus.line_in_valid && n > 0) begin
        if (occ < DEPTH || freed) begin
          for (int i = 0; i < n; i++) mq.push_back(bus.line_in[i*EW +: EW]);
          lq.push_back(n);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("valid", bus.elem_out_valid, m_valid);
      if (m_valid) chk("data", bus.elem_out, m_out);
      chk("almost_full", bus.almost_full, (DEPTH - lq.size()) <= AFT);
      chk("empty", bus.empty, (lq.size() == 0) && !m_valid);
      chk("overflow_err", bus.overflow_err, m_ovf);
    end
  end

  task automatic drive(input logic v, input logic [LW-1:0] l, input int c);
    bus.line_in_valid = v;
    bus.line_in       = l;
    bus.elem_count_in = CW'(c);
  endtask

  task automatic idle();
    drive(1'b0, '0, 0);
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [LW-1:0] ramp(input int base);
    logic [LW-1:0] l;
    for (int i = 0; i < EPL; i++) l[i*EW +: EW] = EW'(base + i);
    return l;
  endfunction

  initial begin
    int exp2 [5];
    exp2 = '{100, 101, 102, 200, 201};
    bus.elem_out_ready = 1'b1;
    idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", bus.elem_out_valid, 0);
    chk("rst_elem", bus.elem_out, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow_err, 0);

    // Single full line, two-cycle latency, then empty.
    drive(1'b1, ramp(0), 16);
    tick();
    idle();
    chk("t1_latency", bus.elem_out_valid, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t1_valid", bus.elem_out_valid, 1);
      chk("t1_elem", bus.elem_out, i);
    end
    tick();
    chk("t1_empty", bus.empty, 1);

    // Back-to-back short lines with no bubble between them.
    drive(1'b1, ramp(100), 3);
    tick();
    drive(1'b1, ramp(200), 2);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("t2_valid", bus.elem_out_valid, 1);
      chk("t2_elem", bus.elem_out, exp2[i]);
      tick();
    end
    chk("t2_end", bus.elem_out_valid, 0);

    // Stall mid-line for five cycles.
    drive(1'b1, ramp(300), 16);
    tick();
    idle();
    tick();
    repeat (4) tick();
    chk("t3_pre", bus.elem_out, 304);
    bus.elem_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_valid", bus.elem_out_valid, 1);
      chk("t3_hold_elem", bus.elem_out, 304);
    end
    bus.elem_out_ready = 1'b1;
    for (int j = 5; j < 16; j++) begin
      tick();
      chk("t3_resume", bus.elem_out, 300 + j);
    end
    tick();
    chk("t3_end", bus.elem_out_valid, 0);

    // Nine lines against a stalled consumer: almost_full from 4, ninth dropped.
    bus.elem_out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, ramp(400 + 16*k), 2);
      tick();
      chk("t4_af", bus.almost_full, k >= 4);
      chk("t4_ovf", bus.overflow_err, k == 9);
    end
    idle();
    repeat (3) tick();
    chk("t4_ovf_sticky", bus.overflow_err, 1);
    bus.elem_out_ready = 1'b1;
    tick();
    chk("t4_drain_first", bus.elem_out, 417);
    repeat (20) tick();
    chk("t4_drained", bus.empty, 1);
    chk("t4_ovf_held", bus.overflow_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_ovf_cleared", bus.overflow_err, 0);

    // Zero-count line discarded silently; count 20 clamps to 16.
    drive(1'b1, ramp(500), 0);
    tick();
    drive(1'b1, ramp(600), 20);
    tick();
    idle();
    chk("t5_noerr", bus.overflow_err, 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("t5_elem", bus.elem_out, 600 + i);
    end
    tick();
    chk("t5_end", bus.elem_out_valid, 0);
    chk("t5_noerr_end", bus.overflow_err, 0);

    // Reset while element 7 is offered; a line presented during reset is ignored.
    drive(1'b1, ramp(700), 16);
    tick();
    idle();
    tick();
    repeat (7) tick();
    chk("t6_e7", bus.elem_out, 707);
    rst = 1'b1;
    drive(1'b1, ramp(900), 16);
    tick();
    rst = 1'b0;
    idle();
    chk("t6_valid", bus.elem_out_valid, 0);
    chk("t6_empty", bus.empty, 1);
    drive(1'b1, ramp(800), 16);
    tick();
    idle();
    tick();
    chk("t6_first_valid", bus.elem_out_valid, 1);
    chk("t6_first", bus.elem_out, 800);
    repeat (16) tick();

    // Randomized traffic, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bus.elem_out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 40) begin
        for (int i = 0; i < EPL; i++) rl[i*EW +: EW] = EW'($urandom());
        drive(1'b1, rl, int'($urandom_range(0, 20)));
      end else begin
        idle();
      end
      rst = ($urandom_range(0, 999) < 3);
      tick();
    end
    rst = 1'b0;
    idle();
    bus.elem_out_ready = 1'b1;
    repeat (200) tick();
    chk("final_empty", bus.empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
